// File: rtl/db_ram_pingpong_buf_if.sv
// Producer/consumer bus of the deblocking ping-pong buffer.
// master = filter core + output stage side, slave = the buffer itself.
interface db_ram_pingpong_buf_if #(
    parameter int WORD_WIDTH = 128,
    parameter int ADDR_WIDTH = 8
);
    localparam int MASK_WIDTH = WORD_WIDTH / 8;

    // write side
    logic                  wr_en_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [MASK_WIDTH-1:0] wr_mask_i;
    logic [WORD_WIDTH-1:0] wr_data_i;
    logic                  wr_done_i;
    logic                  wr_ready_o;
    logic                  wr_bank_o;
    // read side
    logic                  rd_en_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  rd_done_i;
    logic                  rd_ready_o;
    logic                  rd_bank_o;
    logic [WORD_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    // error reporting
    logic                  err_clr_i;
    logic                  err_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_mask_i, wr_data_i, wr_done_i,
        output rd_en_i, rd_addr_i, rd_done_i, err_clr_i,
        input  wr_ready_o, wr_bank_o, rd_ready_o, rd_bank_o,
        input  rd_data_o, rd_valid_o, err_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_mask_i, wr_data_i, wr_done_i,
        input  rd_en_i, rd_addr_i, rd_done_i, err_clr_i,
        output wr_ready_o, wr_bank_o, rd_ready_o, rd_bank_o,
        output rd_data_o, rd_valid_o, err_o
    );
endinterface

// File: rtl/db_ram_pingpong_buf.sv
// Two-bank ping-pong buffer for the deblocking path. The writer owns bank
// wr_sel until it pulses wr_done; the reader owns bank rd_sel until rd_done.
// Storage is split into byte lanes so each lane maps onto a simple
// dual-port RAM and the byte mask becomes the per-lane write enable.

// One byte lane: {bank, addr} indexed storage with a registered read port.
module db_ram_pingpong_lane #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [2**AW];

    // write port, contents never reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // registered read, holds its value when no read is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

module db_ram_pingpong_buf #(
    parameter  int WORD_WIDTH = 128,
    parameter  int ADDR_WIDTH = 8,
    localparam int MASK_WIDTH = WORD_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    db_ram_pingpong_buf_if.slave   bus
);
    logic       wr_sel, rd_sel;
    logic [1:0] full, full_nxt;
    logic       rd_valid, err;
    logic       wr_ready, rd_ready;
    logic       wr_acc, wdone_acc, rd_acc, rdone_acc, err_ev;
    logic [MASK_WIDTH-1:0][7:0] rd_bytes;
    logic [MASK_WIDTH-1:0][7:0] wr_bytes;

    assign wr_ready = ~full[wr_sel];
    assign rd_ready = full[rd_sel];

    // Only accepted operations touch state; the rest are dropped and flagged.
    assign wr_acc    = bus.wr_en_i   & wr_ready;
    assign wdone_acc = bus.wr_done_i & wr_ready;
    assign rd_acc    = bus.rd_en_i   & rd_ready;
    assign rdone_acc = bus.rd_done_i & rd_ready;
    assign err_ev    = ((bus.wr_en_i | bus.wr_done_i) & ~wr_ready) |
                       ((bus.rd_en_i | bus.rd_done_i) & ~rd_ready);

    // Both handoffs accepted in one cycle always hit different banks
    // (writer needs an empty bank, reader a full one), so both apply.
    always_comb begin
        full_nxt = full;
        if (wdone_acc) full_nxt[wr_sel] = 1'b1;
        if (rdone_acc) full_nxt[rd_sel] = 1'b0;
    end

    // bank ownership, read strobe and sticky error state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            full     <= 2'b00;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            full     <= full_nxt;
            rd_valid <= rd_acc;
            if (wdone_acc) wr_sel <= ~wr_sel;
            if (rdone_acc) rd_sel <= ~rd_sel;
            if (err_ev)             err <= 1'b1;
            else if (bus.err_clr_i) err <= 1'b0;
        end
    end

    assign wr_bytes = bus.wr_data_i;

    for (genvar b = 0; b < MASK_WIDTH; b++) begin : g_lane
        db_ram_pingpong_lane #(.AW(ADDR_WIDTH + 1)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (wr_acc & bus.wr_mask_i[b]),
            .waddr ({wr_sel, bus.wr_addr_i}),
            .wdata (wr_bytes[b]),
            .re    (rd_acc),
            .raddr ({rd_sel, bus.rd_addr_i}),
            .rdata (rd_bytes[b])
        );
    end

    assign bus.wr_ready_o = wr_ready;
    assign bus.rd_ready_o = rd_ready;
    assign bus.wr_bank_o  = wr_sel;
    assign bus.rd_bank_o  = rd_sel;
    assign bus.rd_data_o  = rd_bytes;
    assign bus.rd_valid_o = rd_valid;
    assign bus.err_o      = err;
endmodule
